// File: rtl/gpr_sb_pkg.sv
// Shared constants and types for the GPR scoreboard; wbu and idu import the
// same widths so both ends of the register file agree.
package gpr_sb_pkg;

    localparam int GPR_DATA_WIDTH = 32;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int GPR_NUM        = 2 ** GPR_ADDR_WIDTH;

    localparam logic [GPR_ADDR_WIDTH-1:0] GPR_ZERO_ID = '0;

    typedef enum logic {
        GPR_INIT = 1'b0,
        GPR_RUN  = 1'b1
    } gpr_state_t;

endpackage

// File: rtl/gpr_sb_if.sv
// Writeback bus from wbu into the register file: valid/ready handshake plus
// the GPR write payload.
interface gpr_sb_if
    import gpr_sb_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH
);
    logic                  i_sys_valid;
    logic                  o_sys_ready;
    logic                  i_wbu_gpr_wr_en;
    logic [ADDR_WIDTH-1:0] i_wbu_gpr_wr_id;
    logic [DATA_WIDTH-1:0] i_wbu_gpr_wr_data;

    modport master (
        output i_sys_valid,
        output i_wbu_gpr_wr_en,
        output i_wbu_gpr_wr_id,
        output i_wbu_gpr_wr_data,
        input  o_sys_ready
    );

    modport slave (
        input  i_sys_valid,
        input  i_wbu_gpr_wr_en,
        input  i_wbu_gpr_wr_id,
        input  i_wbu_gpr_wr_data,
        output o_sys_ready
    );
endinterface

// File: rtl/gpr_sb_score.sv
// Busy-bit vector for pending GPR destinations. Flush beats a new
// reservation, and a reservation beats a commit to the same index.
module gpr_sb_score
    import gpr_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH,
    parameter int REG_NUM    = 2 ** ADDR_WIDTH
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_id,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_id,
    input  logic                  flush,
    output logic [REG_NUM-1:0]    busy
);

    logic [REG_NUM-1:1] busy_q;
    logic [REG_NUM-1:1] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (set_en && (set_id == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_en && (clr_id == ADDR_WIDTH'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/gpr_sb.sv
// Integer register file with write-through bypass and RAW scoreboard.
// After reset an init walk zeroes entries 1..REG_NUM-1 before writes are accepted.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   GPR_INIT | clearing reg[cnt_q]; not ready, reads 0, busy reads 1
//   GPR_RUN  | accepting writebacks, reservations and flushes
module gpr_sb
    import gpr_sb_pkg::*;
#(
    parameter int DATA_WIDTH = GPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = GPR_ADDR_WIDTH
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    gpr_sb_if.slave               wb,
    input  logic [ADDR_WIDTH-1:0] i_idu_gpr_rd_id_1,
    input  logic [ADDR_WIDTH-1:0] i_idu_gpr_rd_id_2,
    output logic [DATA_WIDTH-1:0] o_gpr_rd_data_1,
    output logic [DATA_WIDTH-1:0] o_gpr_rd_data_2,
    output logic                  o_gpr_rd_busy_1,
    output logic                  o_gpr_rd_busy_2,
    input  logic                  i_idu_gpr_rsv_en,
    input  logic [ADDR_WIDTH-1:0] i_idu_gpr_rsv_id,
    input  logic                  i_sys_flush,
    output logic                  o_gpr_init_done
);

    localparam int REG_NUM = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ID = ADDR_WIDTH'(REG_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ID = '0;

    gpr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_wr;
    logic                  run;
    logic                  commit;
    logic [REG_NUM-1:0]    busy;
    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q <= GPR_INIT;
            cnt_q   <= ADDR_WIDTH'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_wr = 1'b0;
        run     = 1'b0;
        case (state_q)
            GPR_INIT: begin
                init_wr = 1'b1;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ID) begin
                    state_d = GPR_RUN;
                end
            end
            GPR_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = GPR_INIT;
            end
        endcase
    end

    assign wb.o_sys_ready  = run;
    assign o_gpr_init_done = run;

    assign commit = wb.i_sys_valid & run & wb.i_wbu_gpr_wr_en
                  & (wb.i_wbu_gpr_wr_id != ZERO_ID);

    // Entry 0 is never written; reads of index 0 are masked below.
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            if (init_wr) begin
                regs_q[cnt_q] <= '0;
            end else if (commit) begin
                regs_q[wb.i_wbu_gpr_wr_id] <= wb.i_wbu_gpr_wr_data;
            end
        end
    end

    gpr_sb_score #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_NUM    (REG_NUM)
    ) u_score (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .set_en    (i_idu_gpr_rsv_en & run),
        .set_id    (i_idu_gpr_rsv_id),
        .clr_en    (commit),
        .clr_id    (wb.i_wbu_gpr_wr_id),
        .flush     (i_sys_flush),
        .busy      (busy)
    );

    logic hit_1, hit_2;
    assign hit_1 = commit & (wb.i_wbu_gpr_wr_id == i_idu_gpr_rd_id_1);
    assign hit_2 = commit & (wb.i_wbu_gpr_wr_id == i_idu_gpr_rd_id_2);

    always_comb begin
        o_gpr_rd_data_1 = '0;
        o_gpr_rd_data_2 = '0;
        o_gpr_rd_busy_1 = 1'b1;
        o_gpr_rd_busy_2 = 1'b1;
        if (run) begin
            o_gpr_rd_busy_1 = busy[i_idu_gpr_rd_id_1] & ~hit_1;
            o_gpr_rd_busy_2 = busy[i_idu_gpr_rd_id_2] & ~hit_2;
            if (i_idu_gpr_rd_id_1 != ZERO_ID) begin
                o_gpr_rd_data_1 = hit_1 ? wb.i_wbu_gpr_wr_data : regs_q[i_idu_gpr_rd_id_1];
            end
            if (i_idu_gpr_rd_id_2 != ZERO_ID) begin
                o_gpr_rd_data_2 = hit_2 ? wb.i_wbu_gpr_wr_data : regs_q[i_idu_gpr_rd_id_2];
            end
        end
    end

endmodule

// File: tb/tb_gpr_sb.sv
// Bench for gpr_sb: expectations queued as stimulus is driven, drained and
// compared at the following falling edge.
module tb_gpr_sb;
    import gpr_sb_pkg::*;

    localparam int SEL_READY = 0;
    localparam int SEL_DONE  = 1;
    localparam int SEL_BUSY1 = 2;
    localparam int SEL_BUSY2 = 3;
    localparam int SEL_DATA1 = 4;
    localparam int SEL_DATA2 = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd_id_1, rd_id_2, rsv_id;
    logic [31:0] rd_data_1, rd_data_2;
    logic        rd_busy_1, rd_busy_2, rsv_en, flush, init_done;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    gpr_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) wb ();

    gpr_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .i_sys_clk         (clk),
        .i_sys_rst         (rst),
        .wb                (wb),
        .i_idu_gpr_rd_id_1 (rd_id_1),
        .i_idu_gpr_rd_id_2 (rd_id_2),
        .o_gpr_rd_data_1   (rd_data_1),
        .o_gpr_rd_data_2   (rd_data_2),
        .o_gpr_rd_busy_1   (rd_busy_1),
        .o_gpr_rd_busy_2   (rd_busy_2),
        .i_idu_gpr_rsv_en  (rsv_en),
        .i_idu_gpr_rsv_id  (rsv_id),
        .i_sys_flush       (flush),
        .o_gpr_init_done   (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_READY: return {31'b0, wb.o_sys_ready};
            SEL_DONE:  return {31'b0, init_done};
            SEL_BUSY1: return {31'b0, rd_busy_1};
            SEL_BUSY2: return {31'b0, rd_busy_2};
            SEL_DATA1: return rd_data_1;
            default:   return rd_data_2;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.i_sys_valid       = 1'b0;
        wb.i_wbu_gpr_wr_en   = 1'b0;
        wb.i_wbu_gpr_wr_id   = '0;
        wb.i_wbu_gpr_wr_data = '0;
        rsv_en = 1'b0;
        rsv_id = '0;
        flush  = 1'b0;
    endtask

    task automatic commit(input logic [4:0] id, input logic [31:0] data);
        wb.i_sys_valid       = 1'b1;
        wb.i_wbu_gpr_wr_en   = 1'b1;
        wb.i_wbu_gpr_wr_id   = id;
        wb.i_wbu_gpr_wr_data = data;
    endtask

    // Entered at the first INIT cycle; counts not-ready cycles with a bound,
    // while poking writes/reservations that must be ignored.
    task automatic wait_init(input string tag);
        int   n_low   = 0;
        int   bad     = 0;
        logic done_ok = 1'b0;
        commit(5'd2, 32'hffff_ffff);
        rsv_en = 1'b1;
        rsv_id = 5'd3;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            drain();
            if (wb.o_sys_ready === 1'b1) begin
                done_ok = init_done;
                break;
            end
            n_low++;
            if (rd_busy_1 !== 1'b1 || rd_busy_2 !== 1'b1 || init_done !== 1'b0
                || rd_data_1 !== 32'h0 || rd_data_2 !== 32'h0) bad++;
            @(posedge clk);
            #1;
            if (c == 3) idle();
        end
        chk({tag, "_len"}, n_low, 31);
        chk({tag, "_outs"}, bad, 0);
        chk({tag, "_done"}, {31'b0, done_ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rd_id_1 = 5'd5;
        rd_id_2 = 5'd31;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_val("rst_ready", SEL_READY, 0);
        expect_val("rst_done",  SEL_DONE,  0);
        expect_val("rst_busy1", SEL_BUSY1, 1);
        expect_val("rst_busy2", SEL_BUSY2, 1);
        expect_val("rst_data1", SEL_DATA1, 0);
        expect_val("rst_data2", SEL_DATA2, 0);
        wait_init("init");

        for (int i = 0; i < 32; i++) begin
            rd_id_1 = 5'(i);
            rd_id_2 = 5'(31 - i);
            expect_val("clr_data1", SEL_DATA1, 0);
            expect_val("clr_data2", SEL_DATA2, 0);
            expect_val("clr_busy1", SEL_BUSY1, 0);
            expect_val("clr_busy2", SEL_BUSY2, 0);
            step();
        end

        commit(5'd1, 32'h8000_0000);
        rd_id_1 = 5'd1;
        expect_val("wr_bypass", SEL_DATA1, 32'h8000_0000);
        step();
        idle();
        expect_val("wr_stored", SEL_DATA1, 32'h8000_0000);
        step();

        commit(5'd0, 32'h2);
        rd_id_2 = 5'd0;
        expect_val("x0_same", SEL_DATA2, 0);
        step();
        idle();
        expect_val("x0_next", SEL_DATA2, 0);
        step();

        rsv_en = 1'b1;
        rsv_id = 5'd5;
        rd_id_1 = 5'd5;
        expect_val("rsv_same", SEL_BUSY1, 0);
        step();
        idle();
        expect_val("rsv_next", SEL_BUSY1, 1);
        step();
        commit(5'd5, 32'h1);
        expect_val("cm_busy", SEL_BUSY1, 0);
        expect_val("cm_data", SEL_DATA1, 32'h1);
        step();
        idle();
        expect_val("cm_cleared", SEL_BUSY1, 0);
        expect_val("cm_stored", SEL_DATA1, 32'h1);
        step();

        rsv_en = 1'b1;
        rsv_id = 5'd5;
        step();
        commit(5'd5, 32'h7);
        expect_val("both_busy", SEL_BUSY1, 0);
        expect_val("both_data", SEL_DATA1, 32'h7);
        step();
        idle();
        expect_val("both_win", SEL_BUSY1, 1);
        expect_val("both_stored", SEL_DATA1, 32'h7);
        step();
        commit(5'd5, 32'h9);
        step();
        idle();
        expect_val("clr5_busy", SEL_BUSY1, 0);
        expect_val("clr5_data", SEL_DATA1, 32'h9);
        step();

        rsv_en = 1'b1;
        rsv_id = 5'd3;
        step();
        rsv_id = 5'd7;
        step();
        rsv_id = 5'd9;
        step();
        rsv_id = 5'd4;
        flush = 1'b1;
        commit(5'd10, 32'h55);
        rd_id_1 = 5'd3;
        rd_id_2 = 5'd9;
        expect_val("fl_pre3", SEL_BUSY1, 1);
        expect_val("fl_pre9", SEL_BUSY2, 1);
        step();
        idle();
        rd_id_1 = 5'd3;
        rd_id_2 = 5'd4;
        expect_val("fl_id3", SEL_BUSY1, 0);
        expect_val("fl_id4", SEL_BUSY2, 0);
        step();
        rd_id_1 = 5'd7;
        rd_id_2 = 5'd9;
        expect_val("fl_id7", SEL_BUSY1, 0);
        expect_val("fl_id9", SEL_BUSY2, 0);
        step();
        rd_id_1 = 5'd10;
        expect_val("fl_wr10", SEL_DATA1, 32'h55);
        step();

        commit(5'd6, 32'hdead_beef);
        rsv_en = 1'b1;
        rsv_id = 5'd12;
        rd_id_1 = 5'd6;
        expect_val("pre_rst_data", SEL_DATA1, 32'hdead_beef);
        step();
        rst = 1'b1;
        commit(5'd6, 32'h1234);
        rsv_id = 5'd13;
        expect_val("rst_cyc_ready", SEL_READY, 1);
        step();
        rst = 1'b0;
        idle();
        rd_id_1 = 5'd6;
        rd_id_2 = 5'd12;
        expect_val("rst2_ready", SEL_READY, 0);
        wait_init("reinit");
        rd_id_1 = 5'd6;
        expect_val("rst2_id6", SEL_DATA1, 0);
        step();
        for (int i = 1; i < 32; i++) begin
            rd_id_1 = 5'(i);
            expect_val("rst2_busy", SEL_BUSY1, 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpr_sb.md
Name: gpr_sb

Overview:
- Integer register file with scoreboard; the write-side counterpart of the writeback unit.
- Accepts GPR writes from wbu through the i_sys_valid/o_sys_ready handshake and serves two combinational read ports to idu, with write-through bypass.
- Tracks pending destination registers (busy bits) so idu can stall on RAW hazards.
- After reset, a sequential init walk clears every register before accepting writes.

Parameters:
- DATA_WIDTH, 32, width of each GPR and of the write/read data.
- ADDR_WIDTH, 5, register index width; REG_NUM = 2**ADDR_WIDTH entries, entry 0 hardwired to zero.

Ports:
- i_sys_clk  input  1  core clock; all state updates on rising edge.
- i_sys_rst  input  1  synchronous active-high reset.
- i_sys_valid  input  1  wbu has a writeback this cycle.
- o_sys_ready  output  1  block can accept a writeback.
- i_wbu_gpr_wr_en  input  1  writeback targets a GPR.
- i_wbu_gpr_wr_id  input  ADDR_WIDTH  destination index.
- i_wbu_gpr_wr_data  input  DATA_WIDTH  writeback data.
- i_idu_gpr_rd_id_1  input  ADDR_WIDTH  read port 1 index (rs1).
- i_idu_gpr_rd_id_2  input  ADDR_WIDTH  read port 2 index (rs2).
- o_gpr_rd_data_1  output  DATA_WIDTH  read port 1 data.
- o_gpr_rd_data_2  output  DATA_WIDTH  read port 2 data.
- o_gpr_rd_busy_1  output  1  rs1 has a pending write.
- o_gpr_rd_busy_2  output  1  rs2 has a pending write.
- i_idu_gpr_rsv_en  input  1  idu issues an instruction writing i_idu_gpr_rsv_id.
- i_idu_gpr_rsv_id  input  ADDR_WIDTH  reserved destination index.
- i_sys_flush  input  1  pipeline flush; drops all reservations.
- o_gpr_init_done  output  1  init walk complete.

Behaviour:
- FSM states INIT and RUN; reset forces INIT with counter = 1 from any state, including mid-write or mid-init.
- INIT: each cycle writes 0 to reg[counter] and increments counter. The state moves to RUN after entry REG_NUM-1 is written, i.e. INIT lasts REG_NUM-1 cycles (31 at default).
- INIT outputs: o_sys_ready=0, o_gpr_init_done=0, both busy outputs 1, both read data outputs 0. Reservations and commits are ignored.
- Reset values on the cycle after reset: o_sys_ready=0, o_gpr_init_done=0, o_gpr_rd_busy_1/2=1, o_gpr_rd_data_1/2=0, all busy bits 0.
- RUN outputs: o_sys_ready=1 and o_gpr_init_done=1 continuously.
- commit = i_sys_valid & o_sys_ready & i_wbu_gpr_wr_en & (i_wbu_gpr_wr_id != 0). On commit, reg[id] is updated at the clock edge.
- Non-commits: a valid with wr_en=0, or with id 0, completes the handshake but writes nothing.
- Reads are combinational. Index 0 always returns 0.
- Read bypass: if commit is active and wr_id equals rd_id (nonzero), the port returns i_wbu_gpr_wr_data in the same cycle.
- Busy bits: busy_q[REG_NUM-1:1]; bit 0 is constant 0.
  - Set next cycle by i_idu_gpr_rsv_en with nonzero id (RUN only).
  - Cleared next cycle by commit to the same id.
  - Set and clear of the same id in one cycle: bit ends set, because the new issue wins.
  - i_sys_flush clears all bits next cycle and overrides a simultaneous set. Commits during a flush still write data.
- o_gpr_rd_busy_n (RUN) = busy_q[rd_id] & ~(commit & wr_id==rd_id). A reservation in the same cycle does not affect the current-cycle busy output.
- Only one outstanding write per register is tracked; idu stalls issue to a busy destination (WAW), so no counters are needed.

Decomposition:
- Shared package entries:
  - GPR_NUM and GPR_ZERO_ID constants.
  - gpr_state_t enum {GPR_INIT, GPR_RUN}.
  - The widths used by wbu/idu, so both ends agree.
- One sub-module is natural: gpr_sb_score, the busy-bit vector with its set/clear/flush priority logic.
- Storage, init FSM and bypass stay in gpr_sb.

Test Plan:
- Reset then idle:
  - o_sys_ready=0 and busy_1/2=1 for exactly 31 cycles.
  - Then o_gpr_init_done=1 and ready=1.
  - Reading every index 0..31 returns 0.
- Write then read: valid=1, wr_en=1, id=1, data=32'h8000_0000.
  - Same cycle, rd_id_1=1 returns 32'h8000_0000 via bypass.
  - Next cycle, with valid=0, it still returns 32'h8000_0000 from storage.
- x0 protection: commit id=0, data=32'h2 -> rd_id_2=0 reads 0 in the same cycle and the next.
- Scoreboard:
  - rsv id=5 -> busy_1 (rd_id_1=5) is 0 in the same cycle and 1 the next.
  - Commit id=5 data=32'h1 -> busy_1=0 and data=32'h1 in the same cycle.
  - Simultaneous rsv id=5 + commit id=5 -> busy_1=1 the following cycle.
- Flush: reserve ids 3, 7, 9; assert flush together with rsv id=4 -> next cycle busy reads 0 for ids 3, 4, 7 and 9.
- Reset mid-operation:
  - Write 32'hdead_beef to id 6, then reset for one cycle -> ready drops the next cycle and INIT restarts with a full 31-cycle count.
  - Afterwards id 6 reads 0 and no busy bits are set.
